testdrive_axi4_lite_cmd_master: RTL

//  Converts a simple valid/ready command stream (single read/write) into AXI4-Lite master transactions.

---
 rtl/testdrive_axi4_lite_cmd_master.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/testdrive_axi4_lite_cmd_master.sv
// Turns a single-command valid/ready stream into AXI4-Lite master transactions and returns one response per command.
// One transaction outstanding at a time; a response-phase watchdog reports a hung slave and later absorbs its late reply.
module testdrive_axi4_lite_cmd_master #(
  parameter int C_ADDR_WIDTH = 20,
  parameter int C_TIMEOUT    = 1024
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    CMD_VALID,
  output logic                    CMD_READY,
  input  logic                    CMD_WRITE,
  input  logic [C_ADDR_WIDTH-1:0] CMD_ADDR,
  input  logic [31:0]             CMD_WDATA,
  input  logic [3:0]              CMD_WSTRB,
  output logic                    RSP_VALID,
  input  logic                    RSP_READY,
  output logic                    RSP_WRITE,
  output logic [31:0]             RSP_RDATA,
  output logic [1:0]              RSP_RESP,
  output logic                    RSP_TIMEOUT,
  output logic [C_ADDR_WIDTH-1:0] AWADDR,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [31:0]             WDATA,
  output logic [3:0]              WSTRB,
  output logic                    WVALID,
  input  logic                    WREADY,
  input  logic [1:0]              BRESP,
  input  logic                    BVALID,
  output logic                    BREADY,
  output logic [C_ADDR_WIDTH-1:0] ARADDR,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  input  logic [31:0]             RDATA,
  input  logic [1:0]              RRESP,
  input  logic                    RVALID,
  output logic                    RREADY,
  output logic [2:0]              DBG_STATE
);

  // Handshakes: a transfer happens on every rising CLK edge where VALID and READY are both high;
  // a VALID, once raised, stays high with stable payload until that edge.
  typedef enum logic [2:0] {
    S_IDLE, S_WADDR, S_WRESP, S_RADDR, S_RDATA, S_RSP, S_DRAIN
  } state_t;

  localparam int            CW      = (C_TIMEOUT > 1) ? $clog2(C_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WD_LAST = (C_TIMEOUT > 0) ? CW'(C_TIMEOUT - 1) : '0;
  localparam logic          WD_EN   = (C_TIMEOUT > 0);

  state_t                  state_q, state_d;
  logic                    is_write_q, is_write_d;
  logic [CW-1:0]           wd_cnt_q, wd_cnt_d;
  logic                    cmd_ready_d, awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
  logic                    rsp_valid_d, rsp_write_d, rsp_timeout_d;
  logic [31:0]             rsp_rdata_d, wdata_d;
  logic [1:0]              rsp_resp_d;
  logic [3:0]              wstrb_d;
  logic [C_ADDR_WIDTH-1:0] awaddr_d, araddr_d;
  logic                    aw_hs, w_hs, b_hs, r_hs, rsp_hs, wd_expire;

  assign aw_hs     = AWVALID & AWREADY;
  assign w_hs      = WVALID & WREADY;
  assign b_hs      = BVALID & BREADY;
  assign r_hs      = RVALID & RREADY;
  assign rsp_hs    = RSP_VALID & RSP_READY;
  assign wd_expire = WD_EN && (wd_cnt_q == WD_LAST);
  assign DBG_STATE = state_q;

  always_comb begin
    state_d       = state_q;
    is_write_d    = is_write_q;
    wd_cnt_d      = wd_cnt_q;
    cmd_ready_d   = CMD_READY;
    awvalid_d     = AWVALID;
    awaddr_d      = AWADDR;
    wvalid_d      = WVALID;
    wdata_d       = WDATA;
    wstrb_d       = WSTRB;
    bready_d      = BREADY;
    arvalid_d     = ARVALID;
    araddr_d      = ARADDR;
    rready_d      = RREADY;
    rsp_valid_d   = RSP_VALID;
    rsp_write_d   = RSP_WRITE;
    rsp_rdata_d   = RSP_RDATA;
    rsp_resp_d    = RSP_RESP;
    rsp_timeout_d = RSP_TIMEOUT;
    case (state_q)
      S_IDLE: begin
        cmd_ready_d = 1'b1;
        if (CMD_VALID && CMD_READY) begin
          cmd_ready_d = 1'b0;
          is_write_d  = CMD_WRITE;
          if (CMD_WRITE) begin
            awaddr_d  = CMD_ADDR;
            wdata_d   = CMD_WDATA;
            wstrb_d   = CMD_WSTRB;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WADDR;
          end else begin
            araddr_d  = CMD_ADDR;
            arvalid_d = 1'b1;
            state_d   = S_RADDR;
          end
        end
      end
      S_WADDR: begin
        // A VALID already low means that channel finished in an earlier cycle.
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        if ((!AWVALID || aw_hs) && (!WVALID || w_hs)) begin
          bready_d = 1'b1;
          wd_cnt_d = '0;
          state_d  = S_WRESP;
        end
      end
      S_RADDR: begin
        if (aw_hs || ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          wd_cnt_d  = '0;
          state_d   = S_RDATA;
        end
      end
      S_WRESP, S_RDATA: begin
        // A reply landing in the expiry cycle still counts as a normal response.
        if ((state_q == S_WRESP) ? b_hs : r_hs) begin
          bready_d      = 1'b0;
          rready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_write_d   = is_write_q;
          rsp_rdata_d   = (state_q == S_WRESP) ? 32'h0 : RDATA;
          rsp_resp_d    = (state_q == S_WRESP) ? BRESP : RRESP;
          rsp_timeout_d = 1'b0;
          state_d       = S_RSP;
        end else if (wd_expire) begin
          rsp_valid_d   = 1'b1;
          rsp_write_d   = is_write_q;
          rsp_rdata_d   = 32'h0;
          rsp_resp_d    = 2'b10;
          rsp_timeout_d = 1'b1;
          state_d       = S_DRAIN;
        end else if (WD_EN) begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end
      S_RSP: begin
        if (rsp_hs) begin
          rsp_valid_d = 1'b0;
          if (BREADY || RREADY) begin
            state_d = S_DRAIN;
          end else begin
            cmd_ready_d = 1'b1;
            state_d     = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        if (b_hs)   bready_d    = 1'b0;
        if (r_hs)   rready_d    = 1'b0;
        if (rsp_hs) rsp_valid_d = 1'b0;
        if (!bready_d && !rready_d && !rsp_valid_d) begin
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= S_IDLE;
      is_write_q  <= 1'b0;
      wd_cnt_q    <= '0;
      CMD_READY   <= 1'b0;
      AWVALID     <= 1'b0;
      AWADDR      <= '0;
      WVALID      <= 1'b0;
      WDATA       <= '0;
      WSTRB       <= '0;
      BREADY      <= 1'b0;
      ARVALID     <= 1'b0;
      ARADDR      <= '0;
      RREADY      <= 1'b0;
      RSP_VALID   <= 1'b0;
      RSP_WRITE   <= 1'b0;
      RSP_RDATA   <= '0;
      RSP_RESP    <= '0;
      RSP_TIMEOUT <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_write_q  <= is_write_d;
      wd_cnt_q    <= wd_cnt_d;
      CMD_READY   <= cmd_ready_d;
      AWVALID     <= awvalid_d;
      AWADDR      <= awaddr_d;
      WVALID      <= wvalid_d;
      WDATA       <= wdata_d;
      WSTRB       <= wstrb_d;
      BREADY      <= bready_d;
      ARVALID     <= arvalid_d;
      ARADDR      <= araddr_d;
      RREADY      <= rready_d;
      RSP_VALID   <= rsp_valid_d;
      RSP_WRITE   <= rsp_write_d;
      RSP_RDATA   <= rsp_rdata_d;
      RSP_RESP    <= rsp_resp_d;
      RSP_TIMEOUT <= rsp_timeout_d;
    end
  end

endmodule
